// File: rtl/mic_pkg.sv
// mic_pkg -- shared definitions for the I2S microphone receiver.
//   MIC_DATA_W  : default sample width in bits
//   MIC_SLOT_W  : default sck cycles per WS half-frame
//   mic_state_t : receiver FSM state encoding
package mic_pkg;

  localparam int MIC_DATA_W = 24;
  localparam int MIC_SLOT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } mic_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge -- two-flop synchroniser with a third flop for rise detection.
//   clk_in : sampling clock
//   rst    : asynchronous active-high reset, clears all three flops
//   din    : asynchronous input
//   dout   : synchronised level
//   rise   : one-cycle pulse on a synchronised 0->1 transition
module sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [2:0] sh_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[1:0], din};
    end
  end

  assign dout = sh_q[1];
  assign rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/mic_i2s_rx.sv
// mic_i2s_rx -- I2S microphone receiver, oversampled in the clk_in domain.
//   clk_in       : system clock (only clock)
//   rst          : asynchronous active-high reset
//   mic_sck      : I2S bit clock (asynchronous)
//   mic_ws       : word select, 0 = left slot, 1 = right slot
//   mic_sd       : serial data, MSB first, one sck after the WS edge
//   sample_l/r   : last complete stereo pair
//   sample_valid : pair available, held until sample_ready
//   sample_ready : consumer accept
//   overrun      : one-cycle pulse, completed frame dropped
//   frame_err    : one-cycle pulse, WS edge at the wrong bit position
//   clk_lost     : (MIC_I2S_RX_WDOG_EN only) sck missing for WDOG_CYC cycles,
//                  sticky until the next sck rise
module mic_i2s_rx
  import mic_pkg::*;
#(
  parameter int DATA_W   = MIC_DATA_W,
  parameter int SLOT_W   = MIC_SLOT_W,
  parameter int WDOG_CYC = 256
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              mic_sck,
  input  logic              mic_ws,
  input  logic              mic_sd,
  output logic [DATA_W-1:0] sample_l,
  output logic [DATA_W-1:0] sample_r,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              frame_err
`ifdef MIC_I2S_RX_WDOG_EN
  ,
  output logic              clk_lost
`endif
);

  localparam int CNT_W = $clog2(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_DW  = CNT_W'(DATA_W);

  logic sck_s, sck_rise, ws_s, sd_s;

  sync_edge u_sync_sck (.clk_in(clk_in), .rst(rst), .din(mic_sck), .dout(sck_s), .rise(sck_rise));
  sync_edge u_sync_ws  (.clk_in(clk_in), .rst(rst), .din(mic_ws),  .dout(ws_s),  .rise());
  sync_edge u_sync_sd  (.clk_in(clk_in), .rst(rst), .din(mic_sd),  .dout(sd_s),  .rise());

  mic_state_t        state_q, state_d;
  logic              ws_prev_q;
  logic [CNT_W-1:0]  cnt_q, idx;
  logic [DATA_W-1:0] sh_q, left_q;
  logic              left_ok_q;
  logic              ws_fall, ws_up, seam, shift_en, cap, frame_err_d, wdog_hit;

  // WS is only meaningful on sck rises; compare against the last sampled value
  assign ws_fall = sck_rise & ws_prev_q & ~ws_s;
  assign ws_up   = sck_rise & ~ws_prev_q & ws_s;

`ifdef MIC_I2S_RX_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wdog_q;

  assign wdog_hit = !sck_rise && (wdog_q == WD_W'(WDOG_CYC - 1));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wdog_q   <= '0;
      clk_lost <= 1'b0;
    end else if (sck_rise) begin
      wdog_q   <= '0;
      clk_lost <= 1'b0;
    end else if (wdog_q != WD_W'(WDOG_CYC)) begin
      wdog_q <= wdog_q + 1'b1;
      if (wdog_hit) clk_lost <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    seam    = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (ws_fall) begin state_d = ST_LEFT;  seam = 1'b1; end
      ST_LEFT:  if (ws_up)   begin state_d = ST_RIGHT; seam = 1'b1; end
      ST_RIGHT: if (ws_fall) begin state_d = ST_LEFT;  seam = 1'b1; end
      default:  state_d = ST_IDLE;
    endcase
    if (wdog_hit) state_d = ST_IDLE;
  end

  // idx is the bit position of the current sck rise within the slot
  assign idx         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign shift_en    = sck_rise && !seam && (state_q != ST_IDLE) && (idx <= CNT_DW);
  assign cap         = shift_en && (state_q == ST_RIGHT) && (idx == CNT_DW) && left_ok_q;
  assign frame_err_d = seam && (state_q != ST_IDLE) && (cnt_q != CNT_MAX);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      ws_prev_q    <= 1'b0;
      cnt_q        <= '0;
      sh_q         <= '0;
      left_q       <= '0;
      left_ok_q    <= 1'b0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (sck_rise) ws_prev_q <= ws_s;

      if (seam) begin
        cnt_q <= '0;
        sh_q  <= '0;
        if (state_q == ST_LEFT) begin
          left_q    <= sh_q;
          left_ok_q <= (cnt_q == CNT_MAX);
        end
      end else if (sck_rise && (state_q != ST_IDLE)) begin
        cnt_q <= idx;
        if (shift_en) sh_q <= {sh_q[DATA_W-2:0], sd_s};
      end
      if (state_d == ST_IDLE) left_ok_q <= 1'b0;

      frame_err <= frame_err_d;
      overrun   <= cap && sample_valid && !sample_ready;

      // a reload in the handshake cycle keeps valid high for the new pair
      if (cap && (!sample_valid || sample_ready)) begin
        sample_l     <= left_q;
        sample_r     <= {sh_q[DATA_W-2:0], sd_s};
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mic_i2s_rx.sv
// tb_mic_i2s_rx -- randomized I2S frames against a slot-level reference model.
`timescale 1ns/1ps
module tb_mic_i2s_rx;

  localparam int DW       = 24;
  localparam int SW       = 32;
  localparam int CLK_HALF = 8;
  localparam int SCK_HALF = 250;

  logic          clk_in = 1'b0;
  logic          rst, mic_sck, mic_ws, mic_sd, sample_ready;
  logic [DW-1:0] sample_l, sample_r;
  logic          sample_valid, overrun, frame_err;
`ifdef MIC_I2S_RX_WDOG_EN
  logic          clk_lost;
`endif

  mic_i2s_rx #(.DATA_W(DW), .SLOT_W(SW), .WDOG_CYC(256)) dut (
    .clk_in(clk_in), .rst(rst), .mic_sck(mic_sck), .mic_ws(mic_ws), .mic_sd(mic_sd),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .frame_err(frame_err)
`ifdef MIC_I2S_RX_WDOG_EN
    , .clk_lost(clk_lost)
`endif
  );

  always #CLK_HALF clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: tracks WS slot lengths and which frames must arrive.
  logic [2*DW-1:0] exp_q[$];
  int   exp_err = 0, exp_ovr = 0, err_seen = 0, ovr_seen = 0;
  logic ws_last;
  bit   in_sync;
  int   slot_len;

  task automatic model_reset();
    ws_last  = 1'b0;
    in_sync  = 1'b0;
    slot_len = 0;
    exp_q.delete();
  endtask

  // A WS change after a slot shorter than SW bits is a framing error.
  task automatic model_bit(input logic ws);
    if (ws != ws_last) begin
      if (in_sync && slot_len < SW) exp_err++;
      if (!ws) in_sync = 1'b1;
      slot_len = 0;
    end
    slot_len++;
    ws_last = ws;
  endtask

  task automatic sck_bit(input logic ws, input logic sd);
    mic_sck = 1'b0;
    mic_ws  = ws;
    mic_sd  = sd;
    model_bit(ws);
    #SCK_HALF mic_sck = 1'b1;
    #SCK_HALF;
  endtask

  function automatic logic bit_of(input logic [DW-1:0] w, input int k);
    if (k >= 1 && k <= DW) return w[DW-k];
    return logic'($urandom_range(1, 0));
  endfunction

  task automatic send_slot(input logic ws, input logic [DW-1:0] w, input int from, input int to);
    for (int k = from; k <= to; k++) sck_bit(ws, bit_of(w, k));
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int lbits);
    bit deliver;
    deliver = (ws_last == 1'b1) && (lbits == SW);
    send_slot(1'b0, l, 0, lbits - 1);
    if (deliver) begin
      if (!sample_ready && exp_q.size() != 0) exp_ovr++;
      else exp_q.push_back({l, r});
    end
    send_slot(1'b1, r, 0, SW - 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_l"},     32'(sample_l), 0);
    check({tag, "_r"},     32'(sample_r), 0);
    check({tag, "_valid"}, 32'(sample_valid), 0);
    check({tag, "_ovr"},   32'(overrun), 0);
    check({tag, "_ferr"},  32'(frame_err), 0);
  endtask

  logic [2*DW-1:0] mon_e;
  always @(negedge clk_in) begin
    if (!rst) begin
      if (frame_err) err_seen++;
      if (overrun)   ovr_seen++;
      if (sample_valid && sample_ready) begin
        check("pending_expect", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("sample_l", 32'(sample_l), 32'(mon_e[2*DW-1:DW]));
          check("sample_r", 32'(sample_r), 32'(mon_e[DW-1:0]));
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] a_l, a_r, b_l, b_r;
    rst = 1'b1; mic_sck = 1'b0; mic_ws = 1'b0; mic_sd = 1'b0; sample_ready = 1'b1;
    model_reset();
    #100;
    @(negedge clk_in);
    check_zero_outputs("reset");
    rst = 1'b0;

    repeat (4) sck_bit(1'b1, logic'($urandom_range(1, 0)));
    send_frame(24'h123456, 24'hABCDEF, SW);
    send_frame(24'h800000, 24'h7FFFFF, SW);
    for (int i = 0; i < 6; i++) send_frame(DW'($urandom), DW'($urandom), SW);

    // WS toggles early in the left slot, then a clean frame
    send_frame(DW'($urandom), DW'($urandom), 20);
    send_frame(24'h5A5A5A, 24'h0F0F0F, SW);
    check("ferr_count_mid", 32'(err_seen), 32'(exp_err));

    // consumer stalled across two frames
    a_l = DW'($urandom); a_r = DW'($urandom);
    b_l = DW'($urandom); b_r = DW'($urandom);
    sample_ready = 1'b0;
    send_frame(a_l, a_r, SW);
    send_frame(b_l, b_r, SW);
    repeat (10) @(negedge clk_in);
    check("stall_valid", 32'(sample_valid), 1);
    check("stall_l", 32'(sample_l), 32'(a_l));
    check("stall_r", 32'(sample_r), 32'(a_r));
    check("ovr_count_mid", 32'(ovr_seen), 32'(exp_ovr));
    sample_ready = 1'b1;
    repeat (5) @(negedge clk_in);
    check("stall_drained", 32'(sample_valid), 0);

    // reset in the middle of the right slot
    a_l = DW'($urandom); a_r = DW'($urandom);
    send_slot(1'b0, a_l, 0, SW - 1);
    send_slot(1'b1, a_r, 0, 10);
    rst = 1'b1;
    #100;
    @(negedge clk_in);
    check_zero_outputs("midreset");
    model_reset();
    rst = 1'b0;
    send_slot(1'b1, a_r, 11, SW - 1);
    check("post_reset_idle", 32'(sample_valid), 0);
    send_frame(DW'($urandom), DW'($urandom), SW);

`ifdef MIC_I2S_RX_WDOG_EN
    repeat (220) @(negedge clk_in);
    check("clk_lost_early", 32'(clk_lost), 0);
    repeat (60) @(negedge clk_in);
    check("clk_lost_set", 32'(clk_lost), 1);
    sck_bit(1'b1, 1'b0);
    check("clk_lost_clear", 32'(clk_lost), 0);
    send_frame(DW'($urandom), DW'($urandom), SW);
`endif

    send_frame(DW'($urandom), DW'($urandom), SW);
    repeat (20) @(negedge clk_in);
    check("ferr_count", 32'(err_seen), 32'(exp_err));
    check("ovr_count", 32'(ovr_seen), 32'(exp_ovr));
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mic_i2s_rx.md
MIC_I2S_RX -- requirements
Module: mic_i2s_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning sample width in bits (two's complement, MSB first).
REQ-002 SHALL have parameter SLOT_W, default 32, meaning sck cycles per WS half-frame (64 sck per frame).
REQ-003 SHALL have parameter WDOG_CYC, default 256, meaning clk_in cycles without an sck rise before clock loss is declared.
REQ-004 clk_in  input  1  system clock (clk_60MHz domain); the only clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mic_sck  input  1  bit clock (clk_2MHz), asynchronous to clk_in.
REQ-007 mic_ws  input  1  word select (clk_WS), 0 = left slot, 1 = right slot.
REQ-008 mic_sd  input  1  serial data from microphone.
REQ-009 sample_l  output  DATA_W  left sample of the last complete frame.
REQ-010 sample_r  output  DATA_W  right sample of the last complete frame.
REQ-011 sample_valid  output  1  sample pair available; held until accepted.
REQ-012 sample_ready  input  1  consumer accepts the pair when high with sample_valid.
REQ-013 overrun  output  1  one-cycle pulse: completed frame dropped.
REQ-014 frame_err  output  1  one-cycle pulse: WS edge at wrong bit position.

Function
REQ-015 mic_sck, mic_ws, mic_sd SHALL each pass a 2-flop synchroniser; sck rise SHALL be detected by a third flop (rise = sync & ~prev).
REQ-016 mic_ws and mic_sd SHALL be sampled only in the clk_in cycle where sck rise is detected.
REQ-017 FSM states SHALL be IDLE, LEFT, RIGHT; reset state IDLE.
REQ-018 IDLE -> LEFT on a sampled WS 1->0 transition; bit counter cleared to 0.
REQ-019 LEFT -> RIGHT on a sampled WS 0->1 transition; RIGHT -> LEFT on a sampled WS 1->0 transition; bit counter cleared to 0 on each.
REQ-020 Bit 0 of each slot (I2S one-sck delay) SHALL be ignored; bits 1..DATA_W SHALL shift into the slot shift register MSB first; bits beyond DATA_W ignored.
REQ-021 Bit counter SHALL saturate at SLOT_W-1, never wrap.
REQ-022 A WS transition while counter != SLOT_W-1 SHALL pulse frame_err, discard the current slot, and still take the REQ-019 transition (resync).
REQ-023 On the sck rise capturing right-slot bit DATA_W: if sample_valid=0 or sample_ready=1 in that cycle, sample_l/sample_r SHALL load and sample_valid SHALL be 1 in the next cycle.
REQ-024 Otherwise the new pair SHALL be dropped, outputs held, overrun pulsed the next cycle.
REQ-025 sample_valid SHALL clear the cycle after sample_valid & sample_ready, unless reloaded per REQ-023 in that same cycle.
REQ-026 A frame SHALL only be delivered if its left slot was complete and error-free.

Reset
REQ-027 rst SHALL asynchronously force: state IDLE, counter 0, shift registers 0, sample_l=0, sample_r=0, sample_valid=0, overrun=0, frame_err=0, synchroniser flops 0.
REQ-028 rst mid-frame SHALL discard partial data; first delivered frame follows the next WS 1->0 after release.

Configuration
REQ-029 Macro MIC_I2S_RX_WDOG_EN defined: a counter SHALL count clk_in cycles since the last sck rise; on reaching WDOG_CYC, FSM SHALL return to IDLE and output clk_lost (1 bit, sticky until next sck rise) SHALL assert.
REQ-030 Macro undefined: no watchdog logic, no clk_lost port; the FSM waits indefinitely.

Structure
REQ-031 State encoding constants and default DATA_W/SLOT_W SHALL reside in shared package mic_pkg.
REQ-032 The synchroniser plus edge detector SHALL be sub-module sync_edge (one instance per input, rise output used only for sck).

Verification
REQ-033 Frame L=24'h123456, R=24'hABCDEF at 2 MHz sck, 60 MHz clk_in, ready=1 -> sample_l=24'h123456, sample_r=24'hABCDEF, sample_valid one cycle.
REQ-034 Two frames, ready=0 throughout -> first pair held, overrun pulses once, sample_valid stays 1.
REQ-035 WS toggled after 20 bits in left slot -> frame_err pulse, that frame not delivered, next clean frame delivered.
REQ-036 rst asserted at right-slot bit 10 then released -> all outputs 0, first valid frame after next WS falling edge.
REQ-037 With MIC_I2S_RX_WDOG_EN, sck stopped 300 clk_in cycles -> clk_lost=1 at cycle 256, state IDLE; sck resumes -> clk_lost=0.
REQ-038 Left sample 24'h800000, right 24'h7FFFFF -> delivered unchanged (sign boundary).
